// File: rtl/rgb2gray_pkg.sv
// Shared types, coefficient presets and helpers for the RGB-to-luma pipeline.
package rgb2gray_pkg;

    localparam int FRAC_W = 8;
    localparam int ROUND  = 128;

    typedef enum logic [1:0] {
        MODE_601    = 2'd0,
        MODE_709    = 2'd1,
        MODE_AVG    = 2'd2,
        MODE_CUSTOM = 2'd3
    } mode_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } coef_t;

    localparam coef_t COEF_601 = '{r: 8'd77, g: 8'd150, b: 8'd29};
    localparam coef_t COEF_709 = '{r: 8'd54, g: 8'd183, b: 8'd19};
    localparam coef_t COEF_AVG = '{r: 8'd85, g: 8'd85,  b: 8'd86};

    // Clamp v to the largest value representable in w bits (w < 32).
    function automatic logic [31:0] sat(input logic [31:0] v,
                                        input int unsigned w);
        logic [31:0] maxv;
        maxv = (32'd1 << w) - 32'd1;
        return (v > maxv) ? maxv : v;
    endfunction

endpackage

// File: rtl/rgb2gray_coef_sel.sv
// Shadow/active coefficient registers and mode latch; supplies the
// coefficient set used by the beat being accepted this cycle.
module rgb2gray_coef_sel
    import rgb2gray_pkg::*;
#(
    parameter logic [7:0] CR_RST = 8'd77,
    parameter logic [7:0] CG_RST = 8'd150,
    parameter logic [7:0] CB_RST = 8'd29
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] cfg_mode,
    input  logic       cfg_we,
    input  logic [7:0] cfg_cr,
    input  logic [7:0] cfg_cg,
    input  logic [7:0] cfg_cb,
    input  logic       sof_acc,
    output coef_t      coef,
    output logic [1:0] act_mode
);

    localparam coef_t RST_COEF = '{r: CR_RST, g: CG_RST, b: CB_RST};

    mode_e act_mode_q, act_mode_d;
    coef_t active_q, active_d;
    coef_t shadow_q, shadow_d;

    always_comb begin
        shadow_d   = shadow_q;
        act_mode_d = act_mode_q;
        active_d   = active_q;
        if (cfg_we) begin
            shadow_d = '{r: cfg_cr, g: cfg_cg, b: cfg_cb};
        end
        // The sof beat sees the pre-write shadow value.
        if (sof_acc) begin
            act_mode_d = mode_e'(cfg_mode);
            active_d   = shadow_q;
        end
    end

    always_comb begin
        coef = COEF_601;
        unique case (act_mode_d)
            MODE_601:    coef = COEF_601;
            MODE_709:    coef = COEF_709;
            MODE_AVG:    coef = COEF_AVG;
            MODE_CUSTOM: coef = active_d;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_mode_q <= MODE_601;
            active_q   <= RST_COEF;
            shadow_q   <= RST_COEF;
        end else begin
            act_mode_q <= act_mode_d;
            active_q   <= active_d;
            shadow_q   <= shadow_d;
        end
    end

    assign act_mode = act_mode_q;

endmodule

// File: rtl/rgb2gray_pipe.sv
// Three-stage streaming RGB-to-luma converter with rounding, saturation
// and a single global advance for valid/ready backpressure.
module rgb2gray_pipe
    import rgb2gray_pkg::*;
#(
    parameter int         DATA_W = 10,
    parameter logic [7:0] CR_RST = 8'd77,
    parameter logic [7:0] CG_RST = 8'd150,
    parameter logic [7:0] CB_RST = 8'd29
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_r,
    input  logic [DATA_W-1:0] in_g,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_sof,
    input  logic              in_eol,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_y,
    output logic              out_sof,
    output logic              out_eol,
    input  logic [1:0]        cfg_mode,
    input  logic              cfg_we,
    input  logic [7:0]        cfg_cr,
    input  logic [7:0]        cfg_cg,
    input  logic [7:0]        cfg_cb,
    output logic [1:0]        act_mode
);

    localparam int PW = DATA_W + 8;
    localparam int SW = DATA_W + 10;

    logic  advance;
    logic  sof_acc;
    coef_t coef;

    logic          v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic          sof1_q, sof1_d, eol1_q, eol1_d;
    logic          sof2_q, sof2_d, eol2_q, eol2_d;
    logic          sof3_q, sof3_d, eol3_q, eol3_d;
    logic [PW-1:0] pr_q, pr_d, pg_q, pg_d, pb_q, pb_d;
    logic [SW-1:0] sum_q, sum_d;
    logic [SW-1:0] shifted;
    logic [DATA_W-1:0] y_q, y_d;

    assign advance  = !v3_q || out_ready;
    assign in_ready = advance;
    assign sof_acc  = in_valid && advance && in_sof;

    rgb2gray_coef_sel #(
        .CR_RST (CR_RST),
        .CG_RST (CG_RST),
        .CB_RST (CB_RST)
    ) u_coef_sel (
        .clk      (clk),
        .rst      (rst),
        .cfg_mode (cfg_mode),
        .cfg_we   (cfg_we),
        .cfg_cr   (cfg_cr),
        .cfg_cg   (cfg_cg),
        .cfg_cb   (cfg_cb),
        .sof_acc  (sof_acc),
        .coef     (coef),
        .act_mode (act_mode)
    );

    assign shifted = sum_q >> FRAC_W;

    always_comb begin
        v1_d   = v1_q;
        sof1_d = sof1_q;
        eol1_d = eol1_q;
        pr_d   = pr_q;
        pg_d   = pg_q;
        pb_d   = pb_q;
        v2_d   = v2_q;
        sof2_d = sof2_q;
        eol2_d = eol2_q;
        sum_d  = sum_q;
        v3_d   = v3_q;
        sof3_d = sof3_q;
        eol3_d = eol3_q;
        y_d    = y_q;
        if (advance) begin
            v1_d   = in_valid;
            sof1_d = in_sof;
            eol1_d = in_eol;
            pr_d   = PW'(in_r) * PW'(coef.r);
            pg_d   = PW'(in_g) * PW'(coef.g);
            pb_d   = PW'(in_b) * PW'(coef.b);
            v2_d   = v1_q;
            sof2_d = sof1_q;
            eol2_d = eol1_q;
            sum_d  = SW'(pr_q) + SW'(pg_q) + SW'(pb_q) + SW'(ROUND);
            v3_d   = v2_q;
            sof3_d = sof2_q;
            eol3_d = eol2_q;
            y_d    = DATA_W'(sat(32'(shifted), DATA_W));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q   <= 1'b0;
            sof1_q <= 1'b0;
            eol1_q <= 1'b0;
            pr_q   <= '0;
            pg_q   <= '0;
            pb_q   <= '0;
            v2_q   <= 1'b0;
            sof2_q <= 1'b0;
            eol2_q <= 1'b0;
            sum_q  <= '0;
            v3_q   <= 1'b0;
            sof3_q <= 1'b0;
            eol3_q <= 1'b0;
            y_q    <= '0;
        end else begin
            v1_q   <= v1_d;
            sof1_q <= sof1_d;
            eol1_q <= eol1_d;
            pr_q   <= pr_d;
            pg_q   <= pg_d;
            pb_q   <= pb_d;
            v2_q   <= v2_d;
            sof2_q <= sof2_d;
            eol2_q <= eol2_d;
            sum_q  <= sum_d;
            v3_q   <= v3_d;
            sof3_q <= sof3_d;
            eol3_q <= eol3_d;
            y_q    <= y_d;
        end
    end

    assign out_valid = v3_q;
    assign out_y     = y_q;
    assign out_sof   = sof3_q;
    assign out_eol   = eol3_q;

endmodule

// File: tb/tb_rgb2gray_pipe.sv
// Bench for rgb2gray_pipe: vector table, reset/config corner sequences
// and a randomly backpressured stream against a luma model.
module tb_rgb2gray_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready;
    logic [9:0] in_r, in_g, in_b;
    logic       in_sof, in_eol;
    logic       out_valid, out_ready;
    logic [9:0] out_y;
    logic       out_sof, out_eol;
    logic [1:0] cfg_mode;
    logic       cfg_we;
    logic [7:0] cfg_cr, cfg_cg, cfg_cb;
    logic [1:0] act_mode;

    always #5 clk = ~clk;

    rgb2gray_pipe #(
        .DATA_W (10),
        .CR_RST (8'd77),
        .CG_RST (8'd150),
        .CB_RST (8'd29)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_r      (in_r),
        .in_g      (in_g),
        .in_b      (in_b),
        .in_sof    (in_sof),
        .in_eol    (in_eol),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_sof   (out_sof),
        .out_eol   (out_eol),
        .cfg_mode  (cfg_mode),
        .cfg_we    (cfg_we),
        .cfg_cr    (cfg_cr),
        .cfg_cg    (cfg_cg),
        .cfg_cb    (cfg_cb),
        .act_mode  (act_mode)
    );

    typedef struct {
        logic [9:0] y;
        logic       sof;
        logic       eol;
        int         cyc;
    } exp_t;

    typedef struct {
        logic       v;
        logic [1:0] mode;
        int         r, g, b;
        logic       sof, eol, we;
        int         cr, cg, cb;
        int         exp;
    } vec_t;

    exp_t q[$];
    vec_t tbl[13];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int force_exp = -1;
    bit chk_lat = 0;
    bit held = 0;
    bit accepted = 0;
    logic [9:0] h_y;
    logic h_sof, h_eol;

    int m_mode;
    int m_c[3];
    int m_sh[3];

    function automatic int model_y(int r, int g, int b,
                                   int cr, int cg, int cb);
        int s;
        s = (r * cr + g * cg + b * cb + 128) >>> 8;
        if (s > 1023) s = 1023;
        return s;
    endfunction

    task automatic model_reset();
        q.delete();
        held = 0;
        m_mode = 0;
        m_c = '{77, 150, 29};
        m_sh = '{77, 150, 29};
    endtask

    task automatic sample();
        exp_t e;
        int cr, cg, cb, ey;
        cyc++;
        checks++;
        if (in_ready !== (!out_valid || out_ready)) begin
            errors++;
            $display("FAIL in_ready: got %b want %b", in_ready,
                     !out_valid || out_ready);
        end
        if (held) begin
            checks++;
            if (out_valid !== 1'b1 || out_y !== h_y ||
                out_sof !== h_sof || out_eol !== h_eol) begin
                errors++;
                $display("FAIL stall_hold: got v=%b y=%0d sof=%b eol=%b want y=%0d sof=%b eol=%b",
                         out_valid, out_y, out_sof, out_eol, h_y, h_sof, h_eol);
            end
        end
        if (out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL extra_beat: got y=%0d want no output", out_y);
            end else begin
                e = q.pop_front();
                if (out_y !== e.y || out_sof !== e.sof || out_eol !== e.eol) begin
                    errors++;
                    $display("FAIL beat: got y=%0d sof=%b eol=%b want y=%0d sof=%b eol=%b",
                             out_y, out_sof, out_eol, e.y, e.sof, e.eol);
                end
                if (chk_lat) begin
                    checks++;
                    if (cyc - e.cyc != 3) begin
                        errors++;
                        $display("FAIL latency: got %0d want 3", cyc - e.cyc);
                    end
                end
            end
        end
        held = out_valid && !out_ready;
        h_y = out_y;
        h_sof = out_sof;
        h_eol = out_eol;
        accepted = in_valid && in_ready;
        if (accepted) begin
            if (in_sof) begin
                m_mode = int'(cfg_mode);
                m_c = m_sh;
            end
            case (m_mode)
                0: begin cr = 77; cg = 150; cb = 29; end
                1: begin cr = 54; cg = 183; cb = 19; end
                2: begin cr = 85; cg = 85;  cb = 86; end
                default: begin cr = m_c[0]; cg = m_c[1]; cb = m_c[2]; end
            endcase
            ey = model_y(int'(in_r), int'(in_g), int'(in_b), cr, cg, cb);
            if (force_exp >= 0) ey = force_exp;
            e.y = 10'(ey);
            e.sof = in_sof;
            e.eol = in_eol;
            e.cyc = cyc;
            q.push_back(e);
        end
        if (cfg_we) m_sh = '{int'(cfg_cr), int'(cfg_cg), int'(cfg_cb)};
    endtask

    task automatic cycle();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0;
        in_r = '0;
        in_g = '0;
        in_b = '0;
        in_sof = 0;
        in_eol = 0;
        cfg_we = 0;
        cfg_mode = 2'd0;
        cfg_cr = '0;
        cfg_cg = '0;
        cfg_cb = '0;
    endtask

    task automatic drain(input string name);
        in_valid = 0;
        cfg_we = 0;
        out_ready = 1;
        for (int k = 0; k < 50 && q.size() > 0; k++) cycle();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_%s: got %0d beats pending want 0", name, q.size());
        end
    endtask

    task automatic check_mode(input string name, input logic [1:0] want);
        checks++;
        if (act_mode !== want) begin
            errors++;
            $display("FAIL act_mode_%s: got %0d want %0d", name, act_mode, want);
        end
    endtask

    initial begin
        int sent;
        int budget;

        tbl[0]  = '{1, 2'd0, 1023, 0, 0, 1, 0, 0, 0, 0, 0, 308};
        tbl[1]  = '{1, 2'd0, 1023, 1023, 1023, 0, 1, 0, 0, 0, 0, 1023};
        tbl[2]  = '{1, 2'd1, 0, 512, 0, 1, 0, 0, 0, 0, 0, 366};
        tbl[3]  = '{1, 2'd2, 300, 600, 900, 1, 0, 0, 0, 0, 0, 601};
        tbl[4]  = '{0, 2'd3, 0, 0, 0, 0, 0, 1, 255, 255, 255, 0};
        tbl[5]  = '{1, 2'd3, 1023, 1023, 1023, 1, 0, 0, 0, 0, 0, 1023};
        tbl[6]  = '{1, 2'd3, 4, 4, 4, 0, 0, 0, 0, 0, 0, 12};
        tbl[7]  = '{1, 2'd0, 4, 4, 4, 0, 1, 0, 0, 0, 0, 12};
        tbl[8]  = '{1, 2'd0, 4, 4, 4, 1, 0, 0, 0, 0, 0, 4};
        tbl[9]  = '{1, 2'd3, 4, 4, 4, 1, 0, 1, 100, 100, 56, 12};
        tbl[10] = '{1, 2'd3, 8, 0, 0, 0, 0, 0, 0, 0, 0, 8};
        tbl[11] = '{1, 2'd3, 8, 0, 0, 1, 1, 0, 0, 0, 0, 3};
        tbl[12] = '{1, 2'd1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};

        idle_inputs();
        out_ready = 1;
        rst = 1;
        model_reset();
        #3;
        checks++;
        if (out_valid !== 0 || out_y !== 0 || out_sof !== 0 ||
            out_eol !== 0 || act_mode !== 0) begin
            errors++;
            $display("FAIL reset_state: got v=%b y=%0d sof=%b eol=%b mode=%0d want all 0",
                     out_valid, out_y, out_sof, out_eol, act_mode);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            in_valid = tbl[i].v;
            cfg_mode = tbl[i].mode;
            in_r = 10'(tbl[i].r);
            in_g = 10'(tbl[i].g);
            in_b = 10'(tbl[i].b);
            in_sof = tbl[i].sof;
            in_eol = tbl[i].eol;
            cfg_we = tbl[i].we;
            cfg_cr = 8'(tbl[i].cr);
            cfg_cg = 8'(tbl[i].cg);
            cfg_cb = 8'(tbl[i].cb);
            force_exp = tbl[i].exp;
            cycle();
        end
        force_exp = -1;
        idle_inputs();
        check_mode("table", 2'd1);
        drain("table");

        sent = 0;
        budget = 0;
        accepted = 1;
        while (sent < 1000 && budget < 20000) begin
            if (accepted || !in_valid) begin
                in_valid = ($urandom % 4) != 0;
                in_r = 10'($urandom);
                in_g = 10'($urandom);
                in_b = 10'($urandom);
                in_sof = ($urandom % 40) == 0;
                in_eol = ($urandom % 16) == 0;
            end
            cfg_mode = 2'($urandom);
            cfg_we = ($urandom % 25) == 0;
            cfg_cr = 8'($urandom);
            cfg_cg = 8'($urandom);
            cfg_cb = 8'($urandom);
            out_ready = ($urandom % 3) != 0;
            cycle();
            if (accepted) sent++;
            budget++;
        end
        checks++;
        if (sent < 1000) begin
            errors++;
            $display("FAIL random_budget: got %0d beats want 1000", sent);
        end
        drain("random");

        idle_inputs();
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1;
            in_r = 10'(100 * (i + 1));
            in_g = 10'(50);
            in_b = 10'(25);
            in_sof = (i == 0);
            cfg_mode = 2'd2;
            cycle();
        end
        idle_inputs();
        #1 rst = 1;
        #1;
        checks++;
        if (out_valid !== 0 || out_y !== 0) begin
            errors++;
            $display("FAIL mid_reset: got v=%b y=%0d want v=0 y=0", out_valid, out_y);
        end
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        check_mode("after_reset", 2'd0);
        chk_lat = 1;
        in_valid = 1;
        in_r = 10'd1023;
        in_g = 10'd0;
        in_b = 10'd0;
        in_sof = 1;
        cfg_mode = 2'd3;
        force_exp = 308;
        cycle();
        force_exp = -1;
        idle_inputs();
        drain("reset");
        chk_lat = 0;
        check_mode("custom", 2'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rgb2gray_pipe.md
Name: rgb2gray_pipe

Overview:
- Streaming RGB-to-luma converter for the sobel_filter front end.
- Parametrised, pipelined replacement for the fixed 10-bit shift-add grayscale stage.
- Selectable coefficient modes (BT.601, BT.709, average, programmable), with correct rounding and saturation.
- Valid/ready handshake with backpressure; frame-boundary sideband passed through; mode/coefficient changes take effect only at start of frame.

Parameters:
- DATA_W, 10: bits per colour component and per luma output.
- CR_RST, 77: reset value of programmable R coefficient (8-bit, Q0.8).
- CG_RST, 150: reset value of programmable G coefficient.
- CB_RST, 29: reset value of programmable B coefficient.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_r / in_g / in_b  in  DATA_W each  colour components
- in_sof  in  1  first pixel of frame
- in_eol  in  1  last pixel of line
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream ready
- out_y  out  DATA_W  luma
- out_sof / out_eol  out  1 each  delayed sideband
- cfg_mode  in  2  requested mode: 0 BT.601, 1 BT.709, 2 average, 3 programmable
- cfg_we  in  1  write cfg_cr/cg/cb into shadow registers
- cfg_cr / cfg_cg / cfg_cb  in  8 each  programmable coefficients, Q0.8
- act_mode  out  2  mode currently applied

Behaviour:
- Reset (async assert, sync release):
  - all stage valids = 0; out_valid = 0, out_y = 0, out_sof = 0, out_eol = 0.
  - act_mode = 0; shadow and active custom coefficients = CR_RST/CG_RST/CB_RST.
- Reset mid-stream drops all in-flight beats; no partial output.
- Coefficient sets (Q0.8, sum 256):
  - mode 0: 77/150/29
  - mode 1: 54/183/19
  - mode 2: 85/85/86
  - mode 3: active custom registers
- Pipeline: 3 stages.
  - S1: registers three products, each DATA_W+8 bits.
  - S2: registers sum + 128 (round half up), DATA_W+10 bits.
  - S3: shifts right 8, saturates to 2^DATA_W-1, registers out_y.
- Sideband sof/eol travels with each beat through every stage.
- Flow control:
  - advance = !out_valid | out_ready; in_ready = advance (combinational).
  - Every stage register, including valid bits, loads only when advance = 1; otherwise the whole pipe holds.
  - Bubbles are not collapsed.
- Latency: exactly 3 cycles from accepted input to out_valid when out_ready is held at 1; throughput 1 pixel/cycle.
- out_y/out_sof/out_eol stay stable while out_valid & !out_ready.
- Config:
  - cfg_we writes the shadow registers every cycle it is high, independent of flow.
  - On an accepted beat with in_sof = 1, that beat and all later beats use act_mode := cfg_mode and active custom := shadow, with these values sampled in the same cycle.
  - Beats already in flight keep their old coefficients: coefficients are selected in S1 at acceptance.
  - cfg_we together with an accepted sof beat: the new shadow value is not yet visible; the frame uses the pre-write shadow.
  - Before the first sof after reset, mode 0 applies.
- Saturation is only reachable in mode 3 (coefficient sum > 256). Black input gives 0 in every mode.

Decomposition:
- Package rgb2gray_pkg:
  - FRAC_W = 8; ROUND = 128.
  - mode enum {MODE_601, MODE_709, MODE_AVG, MODE_CUSTOM}.
  - coef_t struct {r, g, b} of 8-bit fields and the three preset constants.
  - function sat(): clamps the sum to DATA_W.
- One natural sub-module: rgb2gray_coef_sel. It holds the shadow/active registers and act_mode and outputs the coef_t for S1.

Test Plan:
- Mode 0, ready = 1, sof beat (1023,0,0) then (1023,1023,1023) → y = 308 at cycle 3, then 1023 at cycle 4; out_sof = 1 on the first beat only.
- sof with cfg_mode = 1, pixel (0,512,0) → y = 366. sof with mode 2, pixel (300,600,900) → y = 601.
- Sequence:
  - cfg_we with 255/255/255 and mode 3, then sof with white → y = 1023 (saturated); pixel (4,4,4) → y = 12.
  - Change cfg_mode mid-frame (no sof) → y unchanged until the next sof.
- Random out_ready toggling, 1000 random pixels → output sequence equals the golden model; no drop or duplication; y/sof/eol stable while stalled; in_ready = !out_valid | out_ready.
- Assert rst with 3 beats in flight → out_valid = 0 immediately; after release the first new beat appears at latency 3; act_mode = 0 and custom coefficients = 77/150/29.
- cfg_we in the same cycle as an accepted sof beat → frame uses the old shadow value; the next sof uses the new value.
